approx_mult_pipe: RTL

Parametrised, pipelined unsigned W×W multiplier built from 4×4 nibble tiles, with per-transaction selection between exact and approximate products. In approximate mode the lowest-weight tile diagonals are dropped. The block sits between operand sources and accumulation/DSP-replacement logic in the approximate-arithmetic datapath. Transfers use valid/ready handshakes with full backpressure, an opaque tag carried alongside each product, and a saturating count of approximate transactions.

---
 rtl/approx_mult_pipe.sv | 108 ++++++++++
 1 files changed

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: three-stage W x W unsigned multiplier built from 4x4 nibble
// tiles, with per-beat exact/approximate selection and full valid/ready backpressure.
module approx_mult_pipe #(
  parameter int W         = 8,
  parameter int DROP_DIAG = 1,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      stat_approx_cnt
);
  localparam int N  = W / 4;
  localparam int PW = 2 * W;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] tile_mul(input logic [3:0] x, input logic [3:0] y);
    return {4'd0, x} * {4'd0, y};
  endfunction

  logic             en;
  logic             vld_p0, vld_p1, vld_p2;
  logic [W-1:0]     a_p0, b_p0;
  logic             mode_p0;
  logic [TAG_W-1:0] tag_p0, tag_p1, tag_p2;
  logic [7:0]       tiles_c  [N*N];
  logic [7:0]       tiles_p1 [N*N];
  logic [PW-1:0]    sum_c, sum_p2;
  logic [15:0]      approx_cnt;

  // Whole pipe advances in lockstep; only a stalled valid output holds it.
  assign en              = ~vld_p2 | out_ready;
  assign in_ready        = en;
  assign out_valid       = vld_p2;
  assign out_p           = sum_p2;
  assign out_tag         = tag_p2;
  assign stat_approx_cnt = approx_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      approx_cnt <= 16'd0;
    end else if (en) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (in_valid && in_mode)
        approx_cnt <= sat_inc(approx_cnt);
    end
  end

  // ---- stage p0: operand capture ----
  always_ff @(posedge clk) begin
    if (en) begin
      a_p0    <= in_a;
      b_p0    <= in_b;
      mode_p0 <= in_mode;
      tag_p0  <= in_tag;
    end
  end

  // ---- stage p1: tile products, low diagonals masked in approximate mode ----
  always_comb begin
    tiles_c = '{default: '0};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (mode_p0 && (i + j) < DROP_DIAG)
          tiles_c[i*N+j] = 8'd0;
        else
          tiles_c[i*N+j] = tile_mul(a_p0[4*i +: 4], b_p0[4*j +: 4]);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      tiles_p1 <= tiles_c;
      tag_p1   <= tag_p0;
    end
  end

  // ---- stage p2: weighted sum of tiles ----
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N*N; k++)
      sum_c = sum_c + (PW'(tiles_p1[k]) << (4 * ((k / N) + (k % N))));
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sum_p2 <= sum_c;
      tag_p2 <= tag_p1;
    end
  end

endmodule
